// File: rtl/alu_crypto_arbiter.sv
// Round-robin arbiter sharing one encrypting 8-bit ALU between NUM_REQ valid/ready requesters.
// Optional build macro ALU_ARB_KEY_ROTATE_EN: rotate the key left by one bit on every response handshake.

module alu_8bit_crypto (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [3:0] op,
   input  logic [7:0] key,
   output logic [7:0] result_enc
);

   logic [7:0] result;
   logic [7:0] mixed;

   always_comb begin
      result = '0;
      case (op)
         4'h0:    result = a + b;
         4'h1:    result = a - b;
         4'h2:    result = a & b;
         4'h3:    result = a | b;
         4'h4:    result = a ^ b;
         4'h5:    result = ~a;
         4'h6:    result = a << 1;
         4'h7:    result = a >> 1;
         4'h8:    result = {a[6:0], a[7]};
         4'h9:    result = {a[0], a[7:1]};
         4'hA:    result = a + 8'd1;
         4'hB:    result = a - 8'd1;
         4'hC:    result = a * b;
         4'hD:    result = ~(a & b);
         4'hE:    result = ~(a | b);
         default: result = b;
      endcase
   end

   // Whiten with the key, then rotate left by the key's low three bits.
   assign mixed      = result ^ key;
   assign result_enc = (mixed << key[2:0]) | (mixed >> (4'd8 - {1'b0, key[2:0]}));

endmodule

// state | meaning
// IDLE  | waiting for a request; grants and latches operands combinationally this cycle
// EXEC  | ALU evaluates latched operands with the current key; result registered
// RESP  | rsp_valid held with data/id until the consumer accepts
module alu_crypto_arbiter #(
   parameter int         NUM_REQ  = 4,
   parameter int         ID_W     = 2,
   parameter logic [7:0] KEY_INIT = 8'hA0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*8-1:0] req_a,
   input  logic [NUM_REQ*8-1:0] req_b,
   input  logic [NUM_REQ*4-1:0] req_op,
   input  logic                 key_wr,
   input  logic [7:0]           key_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [7:0]           rsp_data,
   output logic [ID_W-1:0]      rsp_id,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   lat_id;
   logic [7:0]        lat_a;
   logic [7:0]        lat_b;
   logic [3:0]        lat_op;
   logic [7:0]        key;
   logic [7:0]        key_next;
   logic [7:0]        alu_enc;

   logic [7:0]        a_arr  [NUM_REQ];
   logic [7:0]        b_arr  [NUM_REQ];
   logic [3:0]        op_arr [NUM_REQ];

   logic              grant_found;
   logic [ID_W-1:0]   grant_idx;
   logic [NUM_REQ-1:0] grant_oh;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi]  = req_a[8*gi +: 8];
      assign b_arr[gi]  = req_b[8*gi +: 8];
      assign op_arr[gi] = req_op[4*gi +: 4];
   end

   // First valid requester searching upward from ptr+1, wrapping at NUM_REQ.
   always_comb begin
      int              idx;
      logic [ID_W-1:0] idx_s;
      grant_found = 1'b0;
      grant_idx   = '0;
      grant_oh    = '0;
      idx         = 0;
      idx_s       = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx   = (int'(ptr) + i) % NUM_REQ;
         idx_s = ID_W'(idx);
         if (!grant_found && req_valid[idx_s]) begin
            grant_found     = 1'b1;
            grant_idx       = idx_s;
            grant_oh[idx_s] = 1'b1;
         end
      end
   end

   assign req_ready = (state == IDLE) ? grant_oh : '0;

   always_comb begin
      key_next = key;
`ifdef ALU_ARB_KEY_ROTATE_EN
      if (rsp_valid && rsp_ready)
         key_next = {key[6:0], key[7]};
`endif
      if (key_wr)
         key_next = key_wdata;
   end

   alu_8bit_crypto u_alu (
      .a          (lat_a),
      .b          (lat_b),
      .op         (lat_op),
      .key        (key),
      .result_enc (alu_enc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= ID_W'(NUM_REQ - 1);
         lat_id    <= '0;
         lat_a     <= '0;
         lat_b     <= '0;
         lat_op    <= '0;
         key       <= KEY_INIT;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
         busy      <= 1'b0;
      end else begin
         key <= key_next;
         case (state)
            IDLE: begin
               if (grant_found) begin
                  lat_a  <= a_arr[grant_idx];
                  lat_b  <= b_arr[grant_idx];
                  lat_op <= op_arr[grant_idx];
                  lat_id <= grant_idx;
                  busy   <= 1'b1;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               rsp_data  <= alu_enc;
               rsp_id    <= lat_id;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  ptr       <= rsp_id;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_crypto_arbiter.sv
// Self-checking bench for alu_crypto_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model of arbitration, key handling and the ALU.

module tb_alu_crypto_arbiter;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [N*8-1:0] req_a;
   logic [N*8-1:0] req_b;
   logic [N*4-1:0] req_op;
   logic          key_wr;
   logic [7:0]    key_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [7:0]    rsp_data;
   logic [1:0]    rsp_id;
   logic          busy;

   int            checks = 0;
   int            failures = 0;
   int            m_ptr;
   logic [7:0]    m_key;

   alu_crypto_arbiter #(.NUM_REQ(N), .ID_W(2), .KEY_INIT(8'hA0)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .key_wr    (key_wr),
      .key_wdata (key_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference ALU: plain integer arithmetic, then XOR with key and rotate left by key mod 8.
   function automatic logic [7:0] alu_model(input int a, input int b, input int op, input int k);
      int r, x, s;
      case (op)
         0:  r = a + b;
         1:  r = a - b;
         2:  r = a & b;
         3:  r = a | b;
         4:  r = a ^ b;
         5:  r = 255 - a;
         6:  r = a * 2;
         7:  r = a / 2;
         8:  r = a * 2 + a / 128;
         9:  r = a / 2 + (a % 2) * 128;
         10: r = a + 1;
         11: r = a - 1;
         12: r = a * b;
         13: r = 255 - (a & b);
         14: r = 255 - (a | b);
         default: r = b;
      endcase
      r = r & 255;
      x = r ^ k;
      s = k % 8;
      return 8'(((x << s) | (x >> (8 - s))) & 255);
   endfunction

   function automatic int exp_grant(input logic [3:0] v);
      for (int i = 1; i <= N; i++) begin
         int idx;
         idx = (m_ptr + i) % N;
         if (((v >> idx) & 4'd1) != 4'd0) return idx;
      end
      return 0;
   endfunction

   task automatic randomize_buses();
      req_a  = $urandom;
      req_b  = $urandom;
      req_op = 16'($urandom);
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      req_valid = '0; key_wr = 1'b0; rsp_ready = 1'b0;
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_rsp_data",  32'(rsp_data),  32'd0);
      check("rst_rsp_id",    32'(rsp_id),    32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_ptr = N - 1;
      m_key = 8'hA0;
   endtask

   // One full transaction. kw_mode: 0 none, 1 key write in the grant cycle,
   // 2 in the EXEC cycle, 3 in the response handshake cycle. Entered at posedge+1 in IDLE.
   task automatic do_op(input logic [3:0] mask, input int stall, input int kw_mode, input logic [7:0] kval);
      int         g;
      logic [7:0] exp_data;
      req_valid = mask;
      g = exp_grant(mask);
      if (kw_mode == 1) begin key_wr = 1'b1; key_wdata = kval; end
      @(negedge clk);
      check("grant",          32'(req_ready), 32'(1 << g));
      check("idle_busy",      32'(busy),      32'd0);
      check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      if (kw_mode == 1) m_key = kval;
      exp_data = alu_model(int'(8'(req_a >> (8*g))), int'(8'(req_b >> (8*g))),
                           int'(4'(req_op >> (4*g))), int'(m_key));
      @(posedge clk); #1;
      req_valid = '0;
      key_wr = 1'b0;
      randomize_buses();
      if (kw_mode == 2) begin key_wr = 1'b1; key_wdata = kval; end
      @(negedge clk);
      check("exec_busy",      32'(busy),      32'd1);
      check("exec_req_ready", 32'(req_ready), 32'd0);
      check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      key_wr = 1'b0;
      if (kw_mode == 2) m_key = kval;
      if (stall > 0) begin
         rsp_ready = 1'b0;
         req_valid = mask;
         for (int c = 0; c < stall; c++) begin
            @(negedge clk);
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_data",  32'(rsp_data),  32'(exp_data));
            check("stall_rsp_id",    32'(rsp_id),    32'(g));
            check("stall_busy",      32'(busy),      32'd1);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
         end
         req_valid = '0;
      end
      rsp_ready = 1'b1;
      if (kw_mode == 3) begin key_wr = 1'b1; key_wdata = kval; end
      @(negedge clk);
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_data",  32'(rsp_data),  32'(exp_data));
      check("rsp_id",    32'(rsp_id),    32'(g));
      check("rsp_busy",  32'(busy),      32'd1);
      @(posedge clk); #1;
      key_wr = 1'b0;
      rsp_ready = 1'b0;
      m_ptr = g;
`ifdef ALU_ARB_KEY_ROTATE_EN
      m_key = 8'(((int'(m_key) * 2) | (int'(m_key) / 128)) & 255);
`endif
      if (kw_mode == 3) m_key = kval;
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
      key_wr = 1'b0; key_wdata = '0; rsp_ready = 1'b0;
      m_ptr = N - 1;
      m_key = 8'hA0;

      // Reset state, then a directed single op on requester 0.
      apply_reset();
      randomize_buses();
      req_a[7:0] = 8'h03; req_b[7:0] = 8'h05; req_op[3:0] = 4'h0;
      do_op(4'b0001, 0, 0, 8'h00);

      // Fairness from reset: all requesters valid, grant order 0,1,2,3,0,1 at 3-cycle spacing.
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         randomize_buses();
         do_op(4'b1111, 0, 0, 8'h00);
      end

      // Back-pressure for 6 cycles, then an immediate next grant.
      randomize_buses();
      do_op(4'b1111, 6, 0, 8'h00);
      randomize_buses();
      do_op(4'b1111, 0, 0, 8'h00);

      // Key write in EXEC affects only the following op; also in grant and handshake cycles.
      randomize_buses();
      do_op(4'b0110, 0, 2, 8'h3C);
      randomize_buses();
      do_op(4'b0110, 0, 0, 8'h00);
      randomize_buses();
      do_op(4'b1001, 0, 1, 8'h5A);
      randomize_buses();
      do_op(4'b1001, 1, 3, 8'hC3);
      randomize_buses();
      do_op(4'b1111, 0, 0, 8'h00);

      // Key sequence from reset without writes (constant, or rotating when the option is built in).
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         randomize_buses();
         do_op(4'b0001, 0, 0, 8'h00);
      end

      // Reset during EXEC discards the op; requester 0 then beats requester 2.
      randomize_buses();
      key_wr = 1'b1; key_wdata = 8'h77;
      req_valid = 4'b0100;
      @(negedge clk);
      check("midrst_grant", 32'(req_ready), 32'(1 << exp_grant(4'b0100)));
      @(posedge clk); #1;
      req_valid = '0; key_wr = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_busy",      32'(busy),      32'd0);
      check("midrst_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_ptr = N - 1;
      m_key = 8'hA0;
      @(negedge clk);
      check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("postrst_busy",      32'(busy),      32'd0);
      @(posedge clk); #1;
      randomize_buses();
      do_op(4'b0101, 0, 0, 8'h00);

      // Randomized traffic.
      for (int i = 0; i < 30; i++) begin
         randomize_buses();
         do_op(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
